// File: rtl/mux_arb_nto1.sv
// Registered N-to-1 multiplexer with valid/ready handshakes. The selected channel comes from a
// forced index or from a fixed-priority / round-robin arbiter.
module mux_arb_nto1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned RR    = 1,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic             load;
  logic [N-1:0]     elig;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gidx;
  logic [WIDTH-1:0] gdata;
  logic             found;
  logic [SELW-1:0]  idx;
  int unsigned      scan;

  assign load = ~valid_q | out_ready;

  // An out-of-range force_sel matches no channel, so nothing is eligible.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      elig[i] = in_valid[i] & (~force_en | (force_sel == SELW'(i)));
    end
  end

  // Scan starts at ptr in round-robin mode and at 0 in fixed-priority mode.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    scan  = 0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan = k;
      if (RR != 0) begin
        scan = 32'(ptr_q) + k;
      end
      if (scan >= N) begin
        scan = scan - N;
      end
      idx = SELW'(scan);
      if (!found && elig[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gidx        = idx;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = rst_n ? (grant & {N{load}}) : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (|grant) begin
        valid_d = 1'b1;
        data_d  = gdata;
        sel_d   = gidx;
        // Forced transfers leave the fairness pointer alone.
        if ((RR != 0) && !force_en) begin
          ptr_d = (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Drives a round-robin and a fixed-priority instance with shared inputs and checks both against
// a per-cycle reference model of the selection rules.
module tb_mux_arb_nto1;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic            force_en;
  logic [SW-1:0]   force_sel;
  logic            out_ready;

  logic [N-1:0]    rdy [2];
  logic [W-1:0]    odata [2];
  logic            ovalid [2];
  logic [SW-1:0]   osel [2];

  // model state, index 0 = round-robin instance, 1 = fixed-priority instance
  logic            m_valid [2];
  logic [W-1:0]    m_data [2];
  int              m_sel [2];
  int              m_ptr [2];
  bit              outs_known;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mux_arb_nto1 #(.WIDTH(W), .N(N), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .force_en(force_en), .force_sel(force_sel), .out_data(odata[0]), .out_valid(ovalid[0]),
    .out_ready(out_ready), .out_sel(osel[0])
  );

  mux_arb_nto1 #(.WIDTH(W), .N(N), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .force_en(force_en), .force_sel(force_sel), .out_data(odata[1]), .out_valid(ovalid[1]),
    .out_ready(out_ready), .out_sel(osel[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = eligible channel closest to the pointer (round-robin) or lowest index.
  function automatic int exp_grant(input int m);
    int best = -1;
    int bdist = N;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && (!force_en || int'(force_sel) == i)) begin
        int d = (m == 0) ? (i - m_ptr[m] + N) % N : i;
        if (d < bdist) begin
          bdist = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int m);
    int g = exp_grant(m);
    bit load = !m_valid[m] || out_ready;
    if (!rst_n || !load || g < 0) return '0;
    return N'(1) << g;
  endfunction

  // One clock: check before the edge, advance the model at the edge.
  task automatic cycle();
    int g [2];
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("in_ready[%0d]", m), 32'(rdy[m]), 32'(exp_ready(m)));
      if (outs_known) begin
        chk($sformatf("out_valid[%0d]", m), 32'(ovalid[m]), 32'(m_valid[m]));
        if (m_valid[m]) chk($sformatf("out_data[%0d]", m), 32'(odata[m]), 32'(m_data[m]));
        chk($sformatf("out_sel[%0d]", m), 32'(osel[m]), 32'(m_sel[m]));
      end
      g[m] = exp_grant(m);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_valid[m] = 1'b0;
        m_data[m]  = '0;
        m_sel[m]   = 0;
        m_ptr[m]   = 0;
      end else if (!m_valid[m] || out_ready) begin
        if (g[m] >= 0) begin
          m_valid[m] = 1'b1;
          m_data[m]  = in_data[g[m]*W +: W];
          m_sel[m]   = g[m];
          if (m == 0 && !force_en) m_ptr[m] = (g[m] + 1) % N;
        end else begin
          m_valid[m] = 1'b0;
        end
      end
    end
    if (!rst_n) outs_known = 1'b1;
    #1;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0; m_data[m] = '0; m_sel[m] = 0; m_ptr[m] = 0;
    end
    outs_known = 1'b0;

    // reset with every channel requesting
    rst_n = 1'b0; in_valid = '1; in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    force_en = 1'b0; force_sel = '0; out_ready = 1'b1;
    cycle();
    cycle();
    chk("reset out_valid", 32'(ovalid[0]), 0);
    chk("reset out_data", 32'(odata[0]), 0);
    chk("reset out_sel", 32'(osel[0]), 0);

    // forced selection of each channel
    rst_n = 1'b1; force_en = 1'b1;
    for (int fs = 0; fs < N; fs++) begin
      force_sel = SW'(fs);
      #1;
      chk("force in_ready", 32'(rdy[0]), 32'(N'(1) << fs));
      cycle();
      chk("force out_sel", 32'(osel[0]), fs);
      chk("force out_data", 32'(odata[1]), 32'(8'hAA + 8'(fs * 8'h11)));
    end
    force_sel = SW'(2);
    repeat (3) cycle();

    // round-robin rotation from ptr=0 (forced transfers must not have moved it)
    force_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr out_sel", 32'(osel[0]), k % N);
      chk("rr out_valid", 32'(ovalid[0]), 1);
      chk("fp out_sel", 32'(osel[1]), 0);
    end

    // reset once ptr reaches 2
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midreset out_valid", 32'(ovalid[0]), 0);
    rst_n = 1'b1;
    cycle();
    chk("post-reset first grant", 32'(osel[0]), 0);

    // fixed priority starves channel 3 while channel 1 requests
    in_valid = 4'b1010;
    repeat (3) begin
      cycle();
      chk("fp starve", 32'(osel[1]), 1);
    end
    in_valid = 4'b1000;
    cycle();
    chk("fp ch3", 32'(osel[1]), 3);

    // backpressure holding 8'hBB
    force_en = 1'b1; force_sel = SW'(1); in_valid = 4'b0010;
    cycle();
    force_en = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      #1;
      chk("bp in_ready", 32'(rdy[0]), 0);
      cycle();
      chk("bp out_data", 32'(odata[0]), 32'h00BB);
    end
    in_valid = 4'b1000; out_ready = 1'b1;
    cycle();
    chk("bp release data", 32'(odata[0]), 32'h00DD);
    chk("bp release sel", 32'(osel[0]), 3);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      in_valid  = N'($urandom);
      in_data   = $urandom;
      force_en  = ($urandom_range(0, 3) == 0);
      force_sel = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised, registered N-to-1 multiplexer for WIDTH-bit channels with valid/ready handshakes on every input and on the output.
- Selection comes from an explicit select (force mode), or from an internal arbiter when force mode is off. The arbiter is fixed-priority or round-robin.
- Single output register stage; sits between multiple producer datapaths and one shared consumer (e.g. a register-file write port or ALU operand bus).

Parameters:
- WIDTH, 8, data width per channel (>=1)
- N, 4, number of input channels (>=2)
- RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- SELW, $clog2(N), width of select/index fields (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i has data
- in_ready  output  N  channel i transfer accepted this cycle
- force_en  input  1  1 = only channel force_sel is eligible
- force_sel  input  SELW  forced channel index
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  out_data holds an untaken word
- out_ready  input  1  consumer accepts out_data
- out_sel  output  SELW  index of channel that produced out_data

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, the following are cleared:
  - out_valid=0, out_data=0, out_sel=0
  - round-robin pointer ptr=0
- in_ready is combinational and is forced to 0 while rst_n=0.
- Load enable: load = ~out_valid | out_ready. The output register may capture only when load=1.
- Eligibility: elig[i] = in_valid[i] & (~force_en | (force_sel==i)). A force_sel >= N makes no channel eligible.
- Grant, combinational and one-hot or zero:
  - RR=0: the lowest eligible index.
  - RR=1: the first eligible index scanning ptr, ptr+1, … N-1, 0, … ptr-1 (wrap-around).
- in_ready[i] = grant[i] & load. At most one bit is set per cycle. A transfer on channel i means in_valid[i] & in_ready[i].
- On a transfer, at the next edge: out_data <= channel's data, out_sel <= i, out_valid <= 1.
- If load=1 and there is no grant: out_valid <= 0; out_data and out_sel hold.
- If load=0 (out_valid=1 & out_ready=0): out_data, out_sel and out_valid hold stable (backpressure). All in_ready=0.
- Latency: input transfer to out_valid is 1 cycle.
- Throughput: 1 word/cycle when out_ready is held high. A simultaneous output take and input load in the same cycle is legal and loses no data.
- Round-robin pointer:
  - Updates only on a transfer with RR=1 and force_en=0: ptr <= (i==N-1) ? 0 : i+1.
  - Holds otherwise, including for forced transfers and in RR=0.
- force_en may change any cycle. It affects only grant in that cycle and never disturbs a held output word.
- Producers must hold data/valid until ready. The block does not drop or duplicate words.
- Reset mid-operation: any held output word is discarded. out_valid is 0 after the reset edge. No in_ready is asserted during reset.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with all in_valid=1 → in_ready=0, then out_valid=0, out_data=0, out_sel=0.
- Force mode (classic mux), WIDTH=8, N=4: in_data={8'hDD,8'hCC,8'hBB,8'hAA}, all valid, force_en=1, force_sel=2, out_ready=1 → in_ready=4'b0100, next cycle out_data=8'hCC, out_sel=2. Repeat for every force_sel value; then force_sel constant over 3 cycles → ptr unchanged.
- Round-robin fairness: RR=1, force_en=0, all in_valid=1, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
- Fixed priority: RR=0, in_valid=4'b1010 → out_sel=1 every cycle; channel 3 starves. Drop in_valid[1] → out_sel=3 next grant.
- Backpressure: out_valid=1 with out_data=8'hBB and out_ready=0 for 3 cycles while in_valid[3] toggles → out_data stays 8'hBB, in_ready=0. Raise out_ready → same-cycle take plus new load, next out_data=channel 3 data.
- Reset mid-stream: during the round-robin run, assert rst_n=0 for 1 cycle at ptr=2 → out_valid=0 next cycle, then the first grant after release is channel 0.
